// File: rtl/phy_tx_pkg.sv
// ============================================================================
// Module  : phy_tx_pkg
// Brief   : Shared symbols, boundary bit positions and framing states for the
//           two-lane PHY transmit striper.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package phy_tx_pkg;

    localparam logic [7:0] c_STP = 8'hFB;
    localparam logic [7:0] c_SDP = 8'h5C;
    localparam logic [7:0] c_END = 8'hFD;
    localparam logic [7:0] c_EDB = 8'hFE;
    localparam logic [7:0] c_COM = 8'hBC;
    localparam logic [7:0] c_SKP = 8'h1C;
    localparam logic [7:0] c_IDL = 8'h00;

    localparam int c_BND_FIRST = 0;
    localparam int c_BND_LAST  = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_END  = 2'd2,
        ST_SKP  = 2'd3
    } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/tx_skp_scheduler.sv
// ============================================================================
// Module  : tx_skp_scheduler
// Brief   : Free-running SKP interval counter; raises skp_pending on expiry
//           and drops it when the framer enters the SKP ordered set.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tx_skp_scheduler #(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic clk_r_local,
    input  logic rstn_asyn,
    input  logic link_up,
    input  logic skp_clr,
    output logic skp_pending
);

    localparam int              c_CW   = (SKP_INTERVAL > 2) ? $clog2(SKP_INTERVAL) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(SKP_INTERVAL - 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_pend;
    logic            w_expire;

    assign w_expire    = (r_cnt == c_LAST);
    assign skp_pending = r_pend;

    // An expiry coinciding with the clear wins, so no interval is ever lost.
    always_ff @(posedge clk_r_local or negedge rstn_asyn) begin
        if (!rstn_asyn) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else if (!link_up) begin
            r_cnt  <= '0;
            r_pend <= 1'b0;
        end else begin
            r_cnt <= w_expire ? '0 : r_cnt + 1'b1;
            if (w_expire) begin
                r_pend <= 1'b1;
            end else if (skp_clr) begin
                r_pend <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/phy_tx_striper.sv
// ============================================================================
// Module  : phy_tx_striper
// Brief   : Frames DLL words with STP/SDP..END, stripes bytes over two lanes,
//           inserts SKP ordered sets and passes LTSSM traffic when link down.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module phy_tx_striper
    import phy_tx_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic        clk_r_local,
    input  logic        rstn_asyn,
    input  logic        link_up,
    input  logic [7:0]  ltssm_data0,
    input  logic [7:0]  ltssm_data1,
    input  logic        ltssm_k0,
    input  logic        ltssm_k1,
    input  logic        valid_in,
    input  logic [15:0] data_from_DLL,
    input  logic [2:0]  boundary,
    input  logic        type_TLP,
    output logic        throttle,
    output logic [7:0]  lane0_data,
    output logic [7:0]  lane1_data,
    output logic        lane0_k,
    output logic        lane1_k
);

    tx_state_e  r_state;
    tx_state_e  w_state_nxt;
    logic [1:0] r_skp_idx;
    logic [1:0] w_skp_idx_nxt;
    logic [7:0] r_held;
    logic [7:0] w_held_nxt;
    logic [7:0] w_l0;
    logic [7:0] w_l1;
    logic       w_k0;
    logic       w_k1;
    logic       w_skp_pending;
    logic       w_skp_clr;
    logic       w_accept;
    logic       w_unused_bnd;

    assign w_unused_bnd = boundary[2];

    assign throttle  = !link_up
                     || (r_state == ST_END)
                     || (r_state == ST_SKP)
                     || ((r_state == ST_IDLE) && w_skp_pending);
    assign w_accept  = valid_in && !throttle;
    assign w_skp_clr = link_up && (r_state == ST_IDLE) && w_skp_pending;

    tx_skp_scheduler #(
        .SKP_INTERVAL (SKP_INTERVAL)
    ) u_skp_sched (
        .clk_r_local (clk_r_local),
        .rstn_asyn   (rstn_asyn),
        .link_up     (link_up),
        .skp_clr     (w_skp_clr),
        .skp_pending (w_skp_pending)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_skp_idx_nxt = r_skp_idx;
        w_held_nxt    = r_held;
        w_l0          = c_IDL;
        w_l1          = c_IDL;
        w_k0          = 1'b0;
        w_k1          = 1'b0;
        if (!link_up) begin
            w_state_nxt   = ST_IDLE;
            w_skp_idx_nxt = 2'd0;
            w_held_nxt    = 8'h00;
            w_l0          = ltssm_data0;
            w_l1          = ltssm_data1;
            w_k0          = ltssm_k0;
            w_k1          = ltssm_k1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_skp_pending) begin
                        w_state_nxt   = ST_SKP;
                        w_skp_idx_nxt = 2'd0;
                    end else if (w_accept && boundary[c_BND_FIRST]) begin
                        w_l0        = type_TLP ? c_STP : c_SDP;
                        w_k0        = 1'b1;
                        w_l1        = data_from_DLL[15:8];
                        w_held_nxt  = data_from_DLL[7:0];
                        w_state_nxt = boundary[c_BND_LAST] ? ST_END : ST_DATA;
                    end
                end
                ST_DATA: begin
                    w_l0 = r_held;
                    if (w_accept) begin
                        w_l1       = data_from_DLL[15:8];
                        w_held_nxt = data_from_DLL[7:0];
                        if (boundary[c_BND_LAST]) begin
                            w_state_nxt = ST_END;
                        end
                    end else begin
                        // DLL stalled mid-packet: nullify what was sent so far.
                        w_l1        = c_EDB;
                        w_k1        = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_END: begin
                    w_l0        = r_held;
                    w_l1        = c_END;
                    w_k1        = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
                ST_SKP: begin
                    w_l0          = (r_skp_idx == 2'd0) ? c_COM : c_SKP;
                    w_l1          = w_l0;
                    w_k0          = 1'b1;
                    w_k1          = 1'b1;
                    w_skp_idx_nxt = r_skp_idx + 2'd1;
                    if (r_skp_idx == 2'd3) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_r_local or negedge rstn_asyn) begin
        if (!rstn_asyn) begin
            r_state    <= ST_IDLE;
            r_skp_idx  <= 2'd0;
            r_held     <= 8'h00;
            lane0_data <= 8'h00;
            lane1_data <= 8'h00;
            lane0_k    <= 1'b0;
            lane1_k    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_skp_idx  <= w_skp_idx_nxt;
            r_held     <= w_held_nxt;
            lane0_data <= w_l0;
            lane1_data <= w_l1;
            lane0_k    <= w_k0;
            lane1_k    <= w_k1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_phy_tx_striper.sv
// ============================================================================
// Module  : tb_phy_tx_striper
// Brief   : Self-checking bench for phy_tx_striper using a byte-stream model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_phy_tx_striper;

    localparam int c_N = 16;

    logic        clk;
    logic        rstn;
    logic        link_up;
    logic [7:0]  ltssm_data0;
    logic [7:0]  ltssm_data1;
    logic        ltssm_k0;
    logic        ltssm_k1;
    logic        valid_in;
    logic [15:0] data_in;
    logic [2:0]  boundary;
    logic        type_tlp;
    logic        throttle;
    logic [7:0]  lane0_data;
    logic [7:0]  lane1_data;
    logic        lane0_k;
    logic        lane1_k;

    int n_checks = 0;
    int n_errors = 0;

    phy_tx_striper #(
        .SKP_INTERVAL (c_N)
    ) dut (
        .clk_r_local   (clk),
        .rstn_asyn     (rstn),
        .link_up       (link_up),
        .ltssm_data0   (ltssm_data0),
        .ltssm_data1   (ltssm_data1),
        .ltssm_k0      (ltssm_k0),
        .ltssm_k1      (ltssm_k1),
        .valid_in      (valid_in),
        .data_from_DLL (data_in),
        .boundary      (boundary),
        .type_TLP      (type_tlp),
        .throttle      (throttle),
        .lane0_data    (lane0_data),
        .lane1_data    (lane1_data),
        .lane0_k       (lane0_k),
        .lane1_k       (lane1_k)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the wire is a byte stream {K,byte}; each cycle the two
    // oldest bytes go out, lane 0 first.
    logic [8:0] bq[$];
    int         m_ctr;
    bit         m_pend;
    int         m_skp_left;
    logic [8:0] e0;
    logic [8:0] e1;
    bit         ethr;

    initial begin
        e0 = '0; e1 = '0; m_ctr = 0; m_pend = 0; m_skp_left = 0;
        forever begin
            @(posedge clk); #1;
            chk("model_lane0", {7'd0, lane0_k, lane0_data}, rstn ? {7'd0, e0} : 16'h0000);
            chk("model_lane1", {7'd0, lane1_k, lane1_data}, rstn ? {7'd0, e1} : 16'h0000);
            @(negedge clk); #1;
            if (!rstn) begin
                bq.delete(); m_ctr = 0; m_pend = 0; m_skp_left = 0; e0 = '0; e1 = '0;
            end else begin
                ethr = !link_up || bq.size() >= 2 || m_skp_left > 0 || (bq.size() == 0 && m_pend);
                chk("model_throttle", {15'd0, throttle}, {15'd0, ethr});
                e0 = 9'h000; e1 = 9'h000;
                if (!link_up) begin
                    e0 = {ltssm_k0, ltssm_data0}; e1 = {ltssm_k1, ltssm_data1};
                    bq.delete(); m_ctr = 0; m_pend = 0; m_skp_left = 0;
                end else begin
                    if (m_skp_left > 0) begin
                        e0 = (m_skp_left == 4) ? 9'h1BC : 9'h11C;
                        e1 = e0;
                        m_skp_left--;
                    end else if (bq.size() == 0 && m_pend) begin
                        m_skp_left = 4;
                        m_pend = 0;
                    end else if (bq.size() == 0) begin
                        if (valid_in && boundary[0]) begin
                            bq.push_back(type_tlp ? 9'h1FB : 9'h15C);
                            bq.push_back({1'b0, data_in[15:8]});
                            bq.push_back({1'b0, data_in[7:0]});
                            if (boundary[1]) bq.push_back(9'h1FD);
                        end
                    end else if (bq.size() == 1) begin
                        if (valid_in) begin
                            bq.push_back({1'b0, data_in[15:8]});
                            bq.push_back({1'b0, data_in[7:0]});
                            if (boundary[1]) bq.push_back(9'h1FD);
                        end else begin
                            bq.push_back(9'h1FE);
                        end
                    end
                    if (bq.size() >= 2) begin
                        e0 = bq.pop_front();
                        e1 = bq.pop_front();
                    end
                    if (m_ctr == c_N - 1) begin
                        m_ctr = 0;
                        m_pend = 1;
                    end else begin
                        m_ctr++;
                    end
                end
            end
        end
    end

    task automatic cyc(input bit lu, input bit v, input logic [15:0] d, input logic [2:0] b,
                       input bit t, input logic [8:0] x0, input logic [8:0] x1,
                       input bit xthr, input string nm);
        @(negedge clk);
        link_up = lu; valid_in = v; data_in = d; boundary = b; type_tlp = t;
        #1 chk({nm, "_thr"}, {15'd0, throttle}, {15'd0, xthr});
        @(posedge clk); #2;
        chk({nm, "_l0"}, {7'd0, lane0_k, lane0_data}, {7'd0, x0});
        chk({nm, "_l1"}, {7'd0, lane1_k, lane1_data}, {7'd0, x1});
    endtask

    initial begin
        rstn = 1'b0; link_up = 1'b0; valid_in = 1'b0; data_in = '0; boundary = '0; type_tlp = 1'b0;
        ltssm_data0 = 8'hBC; ltssm_k0 = 1'b1; ltssm_data1 = 8'h4A; ltssm_k1 = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("reset_lanes", {6'd0, lane0_k, lane1_k, lane0_data ^ lane1_data}, 16'h0000);
        chk("reset_l0", {8'd0, lane0_data}, 16'h0000);
        chk("reset_thr", {15'd0, throttle}, 16'h0001);

        cyc(0, 0, 16'h0000, 3'b000, 0, 9'h1BC, 9'h04A, 1, "ltssm");

        // 3-word TLP
        cyc(1, 1, 16'h0102, 3'b001, 1, 9'h1FB, 9'h001, 0, "tlp_w0");
        cyc(1, 1, 16'h0304, 3'b000, 1, 9'h002, 9'h003, 0, "tlp_w1");
        cyc(1, 1, 16'h0506, 3'b010, 1, 9'h004, 9'h005, 0, "tlp_w2");
        cyc(1, 0, 16'h0000, 3'b000, 0, 9'h006, 9'h1FD, 1, "tlp_end");
        // single-word DLLP
        cyc(1, 1, 16'hAABB, 3'b011, 0, 9'h15C, 9'h0AA, 0, "dllp_w0");
        cyc(1, 0, 16'h0000, 3'b000, 0, 9'h0BB, 9'h1FD, 1, "dllp_end");
        cyc(1, 0, 16'h0000, 3'b000, 0, 9'h000, 9'h000, 0, "dllp_idle");
        // nullified TLP
        cyc(1, 1, 16'h1122, 3'b001, 1, 9'h1FB, 9'h011, 0, "null_w0");
        cyc(1, 0, 16'h0000, 3'b000, 0, 9'h022, 9'h1FE, 0, "null_edb");
        for (int i = 0; i < 4; i++) cyc(1, 0, 16'h0000, 3'b000, 0, 9'h000, 9'h000, 0, "idle");
        // packet straddling the SKP expiry, then a word held off by the SKP set
        cyc(1, 1, 16'hA1A2, 3'b001, 1, 9'h1FB, 9'h0A1, 0, "span_w0");
        cyc(1, 1, 16'hA3A4, 3'b000, 1, 9'h0A2, 9'h0A3, 0, "span_w1");
        cyc(1, 1, 16'hA5A6, 3'b010, 1, 9'h0A4, 9'h0A5, 0, "span_w2");
        cyc(1, 1, 16'hB1B2, 3'b011, 0, 9'h0A6, 9'h1FD, 1, "span_end");
        cyc(1, 1, 16'hB1B2, 3'b011, 0, 9'h000, 9'h000, 1, "skp_entry");
        cyc(1, 1, 16'hB1B2, 3'b011, 0, 9'h1BC, 9'h1BC, 1, "skp_com");
        for (int i = 0; i < 3; i++) cyc(1, 1, 16'hB1B2, 3'b011, 0, 9'h11C, 9'h11C, 1, "skp_skp");
        cyc(1, 1, 16'hB1B2, 3'b011, 0, 9'h15C, 9'h0B1, 0, "post_skp_w0");
        cyc(1, 0, 16'h0000, 3'b000, 0, 9'h0B2, 9'h1FD, 1, "post_skp_end");
        cyc(1, 0, 16'h0000, 3'b000, 0, 9'h000, 9'h000, 0, "post_skp_idle");
        // link drop mid-packet
        cyc(1, 1, 16'hC1C2, 3'b001, 1, 9'h1FB, 9'h0C1, 0, "drop_w0");
        ltssm_data0 = 8'h55; ltssm_k0 = 1'b0; ltssm_data1 = 8'h66; ltssm_k1 = 1'b1;
        cyc(0, 1, 16'hC3C4, 3'b010, 1, 9'h055, 9'h166, 1, "drop_ltssm");
        for (int k = 0; k <= 16; k++) cyc(1, 0, 16'h0000, 3'b000, 0, 9'h000, 9'h000, k == 16, "relink_idle");
        cyc(1, 0, 16'h0000, 3'b000, 0, 9'h1BC, 9'h1BC, 1, "relink_com");
        repeat (4) @(negedge clk);
        // asynchronous reset mid-packet
        link_up = 1'b1; valid_in = 1'b1; data_in = 16'hD1D2; boundary = 3'b001; type_tlp = 1'b1;
        @(negedge clk);
        boundary = 3'b000; data_in = 16'hD3D4;
        #3 rstn = 1'b0;
        #1;
        chk("async_rst_l0", {7'd0, lane0_k, lane0_data}, 16'h0000);
        chk("async_rst_l1", {7'd0, lane1_k, lane1_data}, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1; valid_in = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            link_up     = ($urandom_range(0, 199) != 0);
            valid_in    = ($urandom_range(0, 3) != 0);
            data_in     = 16'($urandom);
            boundary    = {1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            type_tlp    = 1'($urandom);
            ltssm_data0 = 8'($urandom);
            ltssm_data1 = 8'($urandom);
            ltssm_k0    = 1'($urandom);
            ltssm_k1    = 1'($urandom);
        end
        @(negedge clk);
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
